// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings: opcodes, funct fields, ALU operations and write-back selects.
package rv32i_pkg;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;

    localparam logic [2:0] F3AddSub = 3'b000;
    localparam logic [2:0] F3Sll    = 3'b001;
    localparam logic [2:0] F3Slt    = 3'b010;
    localparam logic [2:0] F3Sltu   = 3'b011;
    localparam logic [2:0] F3Xor    = 3'b100;
    localparam logic [2:0] F3Srl    = 3'b101;
    localparam logic [2:0] F3Or     = 3'b110;
    localparam logic [2:0] F3And    = 3'b111;
    localparam logic [2:0] F3Word   = 3'b010;
    localparam logic [2:0] F3Jalr   = 3'b000;

    localparam logic [2:0] F3Beq  = 3'b000;
    localparam logic [2:0] F3Bne  = 3'b001;
    localparam logic [2:0] F3Blt  = 3'b100;
    localparam logic [2:0] F3Bge  = 3'b101;
    localparam logic [2:0] F3Bltu = 3'b110;
    localparam logic [2:0] F3Bgeu = 3'b111;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    typedef enum logic [3:0] {
        AluAdd, AluSub, AluAnd, AluOr, AluXor, AluSll, AluSrl, AluSra, AluSlt, AluSltu
    } alu_op_e;

    typedef enum logic [2:0] {WbAlu, WbMem, WbLink, WbImmU, WbPcImmU} wb_sel_e;

endpackage

// File: rtl/rv32i_alu.sv
// Combinational RV32I ALU; zero flag drives branch decisions.
module rv32i_alu
    import rv32i_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     op,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = a + b;
        case (op)
            AluAdd:  result = a + b;
            AluSub:  result = a - b;
            AluAnd:  result = a & b;
            AluOr:   result = a | b;
            AluXor:  result = a ^ b;
            AluSll:  result = a << b[4:0];
            AluSrl:  result = a >> b[4:0];
            AluSra:  result = $signed(a) >>> b[4:0];
            AluSlt:  result = {31'b0, $signed(a) < $signed(b)};
            AluSltu: result = {31'b0, a < b};
            default: result = a + b;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/rv32i_processor.sv
// Single-cycle RV32I core: register file, immediate generation, decode and next-PC logic.
module rv32i_processor
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] instruction,
    output logic        write_enable,
    output logic [31:0] address_to_mem,
    output logic [31:0] data_to_mem,
    input  logic [31:0] data_from_mem
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] regs_q [32];

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    alu_op_e     alu_op;
    logic [31:0] alu_b, alu_result, wb_data;
    logic        alu_zero;
    wb_sel_e     wb_sel;
    logic        reg_write, is_store, is_branch, is_jal, is_jalr, branch_taken;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];

    // x0 is cleared on reset and never written, so it always reads zero.
    assign rs1_val = regs_q[rs1];
    assign rs2_val = regs_q[rs2];

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'b0};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    always_comb begin
        alu_op    = AluAdd;
        alu_b     = imm_i;
        wb_sel    = WbAlu;
        reg_write = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        case (opcode)
            OpcOp, OpcOpImm: begin
                reg_write = 1'b1;
                if (opcode == OpcOp) alu_b = rs2_val;
                case (funct3)
                    F3AddSub: alu_op = (opcode == OpcOp && funct7[5]) ? AluSub : AluAdd;
                    F3Sll:    alu_op = AluSll;
                    F3Slt:    alu_op = AluSlt;
                    F3Sltu:   alu_op = AluSltu;
                    F3Xor:    alu_op = AluXor;
                    F3Srl:    alu_op = funct7[5] ? AluSra : AluSrl;
                    F3Or:     alu_op = AluOr;
                    default:  alu_op = AluAnd;
                endcase
                // funct7 is only meaningful for R-type and the immediate shifts.
                if (opcode == OpcOp && funct7 != F7Base &&
                    !(funct7 == F7Alt && (funct3 == F3AddSub || funct3 == F3Srl)))
                    reg_write = 1'b0;
                if (opcode == OpcOpImm &&
                    ((funct3 == F3Sll && funct7 != F7Base) ||
                     (funct3 == F3Srl && funct7 != F7Base && funct7 != F7Alt)))
                    reg_write = 1'b0;
            end
            OpcLoad: begin
                reg_write = (funct3 == F3Word);
                wb_sel    = WbMem;
            end
            OpcStore: begin
                alu_b    = imm_s;
                is_store = (funct3 == F3Word);
            end
            OpcBranch: begin
                alu_b     = rs2_val;
                is_branch = 1'b1;
                case (funct3)
                    F3Beq, F3Bne:   alu_op = AluSub;
                    F3Blt, F3Bge:   alu_op = AluSlt;
                    F3Bltu, F3Bgeu: alu_op = AluSltu;
                    default:        is_branch = 1'b0;
                endcase
            end
            OpcLui: begin
                reg_write = 1'b1;
                wb_sel    = WbImmU;
            end
            OpcAuipc: begin
                reg_write = 1'b1;
                wb_sel    = WbPcImmU;
            end
            OpcJal: begin
                reg_write = 1'b1;
                wb_sel    = WbLink;
                is_jal    = 1'b1;
            end
            OpcJalr: begin
                reg_write = (funct3 == F3Jalr);
                wb_sel    = WbLink;
                is_jalr   = (funct3 == F3Jalr);
            end
            default: ;
        endcase
    end

    rv32i_alu u_alu (
        .a      (rs1_val),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // BEQ/BGE/BGEU take on a zero result, BNE/BLT/BLTU on non-zero.
    assign branch_taken = is_branch & (alu_zero ^ funct3[2] ^ funct3[0]);

    always_comb begin
        pc_d = pc_q + 32'd4;
        if (branch_taken)  pc_d = pc_q + imm_b;
        else if (is_jal)   pc_d = pc_q + imm_j;
        else if (is_jalr)  pc_d = {alu_result[31:1], 1'b0};
    end

    always_comb begin
        case (wb_sel)
            WbMem:    wb_data = data_from_mem;
            WbLink:   wb_data = pc_q + 32'd4;
            WbImmU:   wb_data = imm_u;
            WbPcImmU: wb_data = pc_q + imm_u;
            default:  wb_data = alu_result;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= 32'd0;
            for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
        end else begin
            pc_q <= pc_d;
            if (reg_write && rd != 5'd0) regs_q[rd] <= wb_data;
        end
    end

    assign pc             = pc_q;
    assign write_enable   = is_store & ~reset;
    assign address_to_mem = alu_result;
    assign data_to_mem    = rs2_val;

endmodule

// File: tb/tb_rv32i_processor.sv
// Scoreboard bench for rv32i_processor: instructions driven directly, outputs checked per cycle.
module tb_rv32i_processor;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc, instruction, address_to_mem, data_to_mem, data_from_mem;
    logic        write_enable;

    rv32i_processor dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .instruction    (instruction),
        .write_enable   (write_enable),
        .address_to_mem (address_to_mem),
        .data_to_mem    (data_to_mem),
        .data_from_mem  (data_from_mem)
    );

    always #5 clk = ~clk;

    typedef enum int {SelPc, SelWe, SelAddr, SelData} sel_e;
    typedef struct {
        string       name;
        sel_e        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_pc;

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OpcOp};
    endfunction

    function automatic logic [31:0] enc_i(logic [6:0] op, logic [2:0] f3, logic [4:0] rd,
                                          logic [4:0] rs1, logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(logic [4:0] rs2, logic [4:0] rs1, logic [11:0] imm);
        return {imm[11:5], rs2, rs1, F3Word, imm[4:0], OpcStore};
    endfunction

    function automatic logic [31:0] enc_b(logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2,
                                          logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OpcBranch};
    endfunction

    function automatic logic [31:0] enc_u(logic [6:0] op, logic [4:0] rd, logic [19:0] imm);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(logic [4:0] rd, logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OpcJal};
    endfunction

    function automatic logic [31:0] observe(sel_e s);
        case (s)
            SelPc:   return pc;
            SelWe:   return {31'b0, write_enable};
            SelAddr: return address_to_mem;
            default: return data_to_mem;
        endcase
    endfunction

    function automatic void push(string n, sel_e s, logic [31:0] v);
        sb.push_back('{name: n, sel: s, exp: v});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t        e;
        logic [31:0] got;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin
                    reset = 1'b1;
                    instruction = enc_s(5'd0, 5'd0, 12'd0);
                    push("rst_pc", SelPc, 32'd0);
                    push("rst_we", SelWe, 32'd0);
                end
                1: begin
                    reset = 1'b0;
                    instruction = enc_i(OpcOpImm, F3AddSub, 5'd1, 5'd0, 12'd5);
                    push("first_pc", SelPc, 32'd0);
                    push("first_addi", SelAddr, 32'd5);
                end
                2: begin
                    instruction = enc_s(5'd1, 5'd0, 12'd0);
                    push("after_pc", SelPc, 32'd4);
                    push("after_x1", SelData, 32'd5);
                    push("after_we", SelWe, 32'd1);
                end
                3: begin
                    reset = 1'b1;
                    instruction = enc_i(OpcOpImm, F3AddSub, 5'd1, 5'd0, 12'd9);
                    push("midrst_pc", SelPc, 32'd0);
                    push("midrst_we", SelWe, 32'd0);
                end
                default: begin
                    reset = 1'b0;
                    instruction = enc_s(5'd1, 5'd0, 12'd0);
                    push("postrst_pc", SelPc, 32'd0);
                    push("postrst_x1", SelData, 32'd0);
                    push("postrst_we", SelWe, 32'd1);
                end
            endcase
            #2;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = observe(e.sel);
                n_vec++;
                if (got !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, got, e.exp);
                end
            end
            tick();
        end
        exp_pc = 32'd4;
    endtask

    task automatic test_arith();
        exp_t        e;
        logic [31:0] got;
        for (int i = 0; i < 17; i++) begin
            push($sformatf("arith%0d_pc", i), SelPc, exp_pc);
            case (i)
                0: begin
                    instruction = enc_i(OpcOpImm, F3AddSub, 5'd1, 5'd0, 12'hFFD);
                    push("addi_neg", SelAddr, 32'hFFFF_FFFD);
                end
                1: begin
                    instruction = enc_i(OpcOpImm, F3AddSub, 5'd2, 5'd0, 12'd7);
                    push("addi_pos", SelAddr, 32'd7);
                end
                2: begin
                    instruction = enc_r(F7Alt, 5'd2, 5'd1, F3AddSub, 5'd3);
                    push("sub", SelAddr, 32'hFFFF_FFF6);
                end
                3: begin
                    instruction = enc_r(F7Base, 5'd2, 5'd1, F3Slt, 5'd4);
                    push("slt", SelAddr, 32'd1);
                end
                4: begin
                    instruction = enc_r(F7Base, 5'd2, 5'd1, F3Sltu, 5'd5);
                    push("sltu", SelAddr, 32'd0);
                end
                5: begin
                    instruction = enc_i(OpcOpImm, F3Srl, 5'd6, 5'd1, 12'h401);
                    push("srai", SelAddr, 32'hFFFF_FFFE);
                end
                6: begin
                    instruction = enc_i(OpcOpImm, F3Srl, 5'd7, 5'd1, 12'h001);
                    push("srli", SelAddr, 32'h7FFF_FFFE);
                end
                7: begin
                    instruction = enc_s(5'd3, 5'd0, 12'd0);
                    push("x3_commit", SelData, 32'hFFFF_FFF6);
                end
                8: begin
                    instruction = enc_s(5'd6, 5'd0, 12'd4);
                    push("x6_addr", SelAddr, 32'd4);
                    push("x6_commit", SelData, 32'hFFFF_FFFE);
                end
                9: begin
                    instruction = enc_r(F7Base, 5'd2, 5'd1, F3And, 5'd8);
                    push("and", SelAddr, 32'd5);
                end
                10: begin
                    instruction = enc_i(OpcOpImm, F3Xor, 5'd9, 5'd2, 12'h0F0);
                    push("xori", SelAddr, 32'h0000_00F7);
                end
                11: begin
                    instruction = enc_r(F7Base, 5'd2, 5'd2, F3Sll, 5'd10);
                    push("sll", SelAddr, 32'h0000_0380);
                end
                12: begin
                    instruction = enc_r(F7Alt, 5'd2, 5'd1, F3Srl, 5'd11);
                    push("sra", SelAddr, 32'hFFFF_FFFF);
                end
                13: begin
                    instruction = enc_i(OpcOpImm, F3AddSub, 5'd12, 5'd0, 12'h055);
                    push("rdw_init", SelAddr, 32'h55);
                end
                14: begin
                    instruction = enc_i(OpcOpImm, F3AddSub, 5'd12, 5'd12, 12'd1);
                    push("rdw_inc", SelAddr, 32'h56);
                end
                15: begin
                    instruction = enc_s(5'd12, 5'd0, 12'd0);
                    push("rdw_new", SelData, 32'h56);
                end
                default: begin
                    instruction = enc_r(F7Base, 5'd2, 5'd1, F3Or, 5'd14);
                    push("or", SelAddr, 32'hFFFF_FFFF);
                end
            endcase
            #2;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = observe(e.sel);
                n_vec++;
                if (got !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, got, e.exp);
                end
            end
            tick();
            exp_pc += 32'd4;
        end
    endtask

    task automatic test_memory();
        exp_t        e;
        logic [31:0] got;
        for (int i = 0; i < 5; i++) begin
            push($sformatf("mem%0d_pc", i), SelPc, exp_pc);
            data_from_mem = 32'd0;
            case (i)
                0: begin
                    instruction = enc_s(5'd2, 5'd0, 12'd8);
                    push("sw_we", SelWe, 32'd1);
                    push("sw_addr", SelAddr, 32'd8);
                    push("sw_data", SelData, 32'd7);
                end
                1: begin
                    instruction = enc_i(OpcLoad, F3Word, 5'd13, 5'd0, 12'd8);
                    data_from_mem = 32'd7;
                    push("lw_we", SelWe, 32'd0);
                    push("lw_addr", SelAddr, 32'd8);
                end
                2: begin
                    instruction = enc_s(5'd13, 5'd0, 12'd0);
                    push("lw_result", SelData, 32'd7);
                end
                3: begin
                    instruction = enc_i(OpcLoad, 3'b000, 5'd13, 5'd0, 12'd8);
                    data_from_mem = 32'h99;
                    push("lb_nop_we", SelWe, 32'd0);
                end
                default: begin
                    instruction = enc_s(5'd13, 5'd0, 12'd0);
                    push("lb_nop_keep", SelData, 32'd7);
                end
            endcase
            #2;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = observe(e.sel);
                n_vec++;
                if (got !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, got, e.exp);
                end
            end
            tick();
            exp_pc += 32'd4;
        end
        data_from_mem = 32'd0;
    endtask

    task automatic test_branch();
        exp_t        e;
        logic [31:0] got, nxt;
        for (int i = 0; i < 8; i++) begin
            push($sformatf("br%0d_pc", i), SelPc, exp_pc);
            nxt = exp_pc + 32'd4;
            case (i)
                0: begin
                    instruction = enc_b(F3Beq, 5'd0, 5'd0, 13'd12);
                    nxt = exp_pc + 32'd12;
                    push("beq_we", SelWe, 32'd0);
                end
                1: instruction = enc_b(F3Bne, 5'd0, 5'd0, 13'd12);
                2: begin
                    instruction = enc_b(F3Blt, 5'd1, 5'd2, 13'h1FF8);
                    nxt = exp_pc - 32'd8;
                end
                3: instruction = enc_b(F3Bltu, 5'd1, 5'd2, 13'd16);
                4: begin
                    instruction = enc_b(F3Bge, 5'd2, 5'd1, 13'd8);
                    nxt = exp_pc + 32'd8;
                end
                5: instruction = enc_b(F3Bgeu, 5'd2, 5'd1, 13'd8);
                6: instruction = enc_b(3'b010, 5'd0, 5'd0, 13'd12);
                default: begin
                    instruction = enc_b(F3Bgeu, 5'd1, 5'd2, 13'd20);
                    nxt = exp_pc + 32'd20;
                end
            endcase
            #2;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = observe(e.sel);
                n_vec++;
                if (got !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, got, e.exp);
                end
            end
            tick();
            exp_pc = nxt;
        end
    endtask

    task automatic test_jump();
        exp_t        e;
        logic [31:0] got, nxt, link, auipc_val, link2;
        link = 32'd0;
        auipc_val = 32'd0;
        link2 = 32'd0;
        for (int i = 0; i < 10; i++) begin
            push($sformatf("jmp%0d_pc", i), SelPc, exp_pc);
            nxt = exp_pc + 32'd4;
            case (i)
                0: begin
                    instruction = enc_j(5'd1, 21'd8);
                    link = exp_pc + 32'd4;
                    nxt = exp_pc + 32'd8;
                end
                1: begin
                    instruction = enc_s(5'd1, 5'd0, 12'd0);
                    push("jal_link", SelData, link);
                end
                2: begin
                    instruction = enc_i(OpcJalr, F3Jalr, 5'd0, 5'd1, 12'd1);
                    push("jalr_sum", SelAddr, link + 32'd1);
                    nxt = link;
                end
                3: instruction = enc_u(OpcLui, 5'd7, 20'h12345);
                4: begin
                    instruction = enc_u(OpcAuipc, 5'd8, 20'h00001);
                    auipc_val = exp_pc + 32'h1000;
                end
                5: begin
                    instruction = enc_s(5'd7, 5'd0, 12'd0);
                    push("lui", SelData, 32'h1234_5000);
                end
                6: begin
                    instruction = enc_s(5'd8, 5'd0, 12'd0);
                    push("auipc", SelData, auipc_val);
                end
                7: begin
                    instruction = enc_j(5'd0, 21'h1FFFF0);
                    nxt = exp_pc - 32'd16;
                end
                8: begin
                    instruction = enc_i(OpcJalr, F3Jalr, 5'd5, 5'd0, 12'd0);
                    link2 = exp_pc + 32'd4;
                    nxt = 32'd0;
                end
                default: begin
                    instruction = enc_s(5'd5, 5'd0, 12'd0);
                    push("jalr_link", SelData, link2);
                end
            endcase
            #2;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = observe(e.sel);
                n_vec++;
                if (got !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, got, e.exp);
                end
            end
            tick();
            exp_pc = nxt;
        end
    endtask

    task automatic test_x0_illegal();
        exp_t        e;
        logic [31:0] got;
        for (int i = 0; i < 6; i++) begin
            push($sformatf("ill%0d_pc", i), SelPc, exp_pc);
            case (i)
                0: begin
                    instruction = enc_i(OpcOpImm, F3AddSub, 5'd0, 5'd0, 12'd9);
                    push("x0_addi", SelAddr, 32'd9);
                end
                1: begin
                    instruction = enc_s(5'd0, 5'd0, 12'd0);
                    push("x0_reads0", SelData, 32'd0);
                end
                2: begin
                    instruction = 32'h0020_A07F;
                    push("opc7f_we", SelWe, 32'd0);
                end
                3: instruction = enc_r(7'h01, 5'd2, 5'd1, F3AddSub, 5'd3);
                4: instruction = enc_i(OpcOpImm, F3Sll, 5'd3, 5'd1, 12'h401);
                default: begin
                    instruction = enc_s(5'd3, 5'd0, 12'd0);
                    push("bad_f7_nowrite", SelData, 32'hFFFF_FFF6);
                end
            endcase
            #2;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = observe(e.sel);
                n_vec++;
                if (got !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, got, e.exp);
                end
            end
            tick();
            exp_pc += 32'd4;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        instruction   = 32'd0;
        data_from_mem = 32'd0;
        exp_pc        = 32'd0;
        test_reset();
        test_arith();
        test_memory();
        test_branch();
        test_jump();
        test_x0_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rv32i_processor.md
# rv32i_processor

Single-cycle 32-bit RISC-V (RV32I integer subset) processor core with Harvard memory ports. Each clock cycle fetches the word at `pc` from an external combinational instruction memory, executes it, and commits the register, memory and PC updates at the rising clock edge. It sits under the system top level between a 64-word instruction ROM and a 64-word data RAM. Both memories read combinationally and write synchronously.

## Interface
- No parameters.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-high.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `pc` output 32: address of the current instruction. The top level uses `pc[7:2]`.
- `instruction` input 32: instruction word at `pc`, valid combinationally.
- `write_enable` output 1: data-memory store strobe, sampled by the memory at the rising edge.
- `address_to_mem` output 32: data-memory byte address (word-aligned use).
- `data_to_mem` output 32: store data, equal to rs2.
- `data_from_mem` input 32: combinational load data for `address_to_mem`.

## Operation
- **Register file**
  - 32×32 registers; x0 always reads 0 and writes to it are ignored.
  - Two combinational read ports and one synchronous write port.
- **Supported instructions**
  - R-type (opcode 0110011): ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - I-type ALU (0010011): ADDI, ANDI, ORI, XORI, SLTI, SLTIU, SLLI, SRLI, SRAI.
  - LW (0000011, funct3 010); SW (0100011, funct3 010).
  - Branches (1100011): BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LUI (0110111), AUIPC (0010111), JAL (1101111), JALR (1100111).
- **Immediates**: I, S, B, U, J formats, sign-extended from instruction bit 31. B and J offsets have bit 0 = 0.
- **Shifts**: shift amount = operand[4:0]. SRA and SRAI are arithmetic. SLT is signed; SLTU is unsigned.
- **Loads**
  - `address_to_mem` = rs1 + imm.
  - rd ← `data_from_mem` (full word).
- **Stores**
  - `address_to_mem` = rs1 + imm; `data_to_mem` = rs2.
  - `write_enable` = 1 only while executing SW.
- **Address output for other instructions**: `address_to_mem` = ALU result; `write_enable` = 0.
- **Next PC**
  - Default: pc+4.
  - Taken branch: pc+immB.
  - JAL: pc+immJ.
  - JALR: (rs1+immI) & ~1.
- **Link write**: JAL and JALR write pc+4 to rd.
- **LUI / AUIPC**: LUI writes immU; AUIPC writes pc+immU.
- **Unrecognised opcode or funct combination**
  - Executes as a NOP: pc+4, no register write, `write_enable` = 0.
- **Overflow**: all arithmetic is modulo 2^32; there are no traps or exceptions.

## Timing
- **Reset**
  - `pc` = 0 and all registers = 0 immediately on reset assertion, independent of `clk`.
  - While reset is asserted, `write_enable` = 0.
- **Execution**: one instruction per cycle.
  - Decode, ALU and next-PC logic are purely combinational from `instruction`, the register file and `data_from_mem`.
- **Commit**: at each rising `clk` edge with reset low, pc ← next PC and rd ← result, both committed in the same edge.
- **Read-during-write**: a register read in the cycle of its write returns the old value. The new value is visible from the next cycle.
- **Reset mid-operation**: reset asserted mid-operation aborts the current instruction; no register or PC update is committed.
- **Stores**: `write_enable`, address and data are stable before the edge; the memory captures them at that edge.

## Structure
- **Shared package** `rv32i_pkg` holds:
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR);
  - funct3/funct7 constants;
  - ALU-operation enum (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU).
- **Sub-module** `rv32i_alu`: combinational, inputs a, b and op; outputs result plus an equality/less-than flag used by branches.
- **Top file** holds the register file, immediate generator, control decoder and PC logic.

## Test plan
- Reset asserted, then released: `pc` = 0 immediately. After the first edge with ADDI x1,x0,5, `pc` = 4 and x1 = 5.
- Arithmetic sequence:
  - ADDI x1,x0,-3; ADDI x2,x0,7; then SUB, SLT and SLTU of x1,x2 into x3–x5.
  - Required: SUB = 0xFFFFFFF6, SLT = 1, SLTU = 0.
  - SRAI x1,1 = 0xFFFFFFFE; SRLI x1,1 = 0x7FFFFFFE.
- Memory access:
  - SW x2,8(x0): `write_enable` = 1, `address_to_mem` = 8, `data_to_mem` = 7.
  - LW x6,8(x0) with `data_from_mem` = 7: x6 = 7 and `write_enable` = 0.
- Branches: BEQ x0,x0,+12 at pc 0x10 → next `pc` = 0x1C; BNE x0,x0,+12 → next `pc` = 0x14; BLT −3 < 7 taken, BLTU not taken.
- Jumps and upper immediates:
  - JAL x1,+8 at pc 0x20 → x1 = 0x24, `pc` = 0x28.
  - JALR x0,1(x1) → `pc` = 0x24 (bit 0 cleared).
  - LUI x7,0x12345 → 0x12345000; AUIPC at 0x30 with imm 1 → 0x1030.
- x0 and illegal opcodes: ADDI x0,x0,9 leaves x0 reading 0; opcode 0x7F executes as NOP (pc+4, no write strobe).
